hazard_ctrl: RTL

- Parametrised hazard detection and forwarding controller for the in-order RISC-V pipeline.
- Sits beside the ID stage.
- Keeps a shift-register record (valid, rd, reg_wr, is_load) of the instructions in flight in stages EX..WB.
- Drives the stall, bubble and forwarding-select controls, and holds saturating performance counters for stalls and flushes.
- Stalls freeze only PC and IF/ID. A bubble is injected into ID/EX, and downstream stages keep advancing.

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding control for the in-order pipeline, placed beside ID.
// Tracks in-flight writers in EX..WB and produces stall, bubble, forwarding selects and perf counters.
`timescale 1ns/1ps
module hazard_ctrl #(
    parameter int NSTAGES      = 3,
    parameter int RIDX_W       = 5,
    parameter int FWD_EN       = 1,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_STAGES = 1,
    parameter int CNT_W        = 16,
    localparam int SEL_W       = $clog2(NSTAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [RIDX_W-1:0] id_rs1_idx,
    input  logic              id_rs1_used,
    input  logic [RIDX_W-1:0] id_rs2_idx,
    input  logic              id_rs2_used,
    input  logic [RIDX_W-1:0] id_rd_idx,
    input  logic              id_reg_wr,
    input  logic              id_rd_mem,
    input  logic              flush,
    output logic              stall,
    output logic              id_ex_bubble,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [NSTAGES-1:0] valid_q, valid_d;
    logic [NSTAGES-1:0] wr_q, wr_d;
    logic [NSTAGES-1:0] load_q, load_d;
    logic [RIDX_W-1:0]  rd_q [NSTAGES];
    logic [RIDX_W-1:0]  rd_d [NSTAGES];
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic [NSTAGES-1:0] match_a, match_b, haz_stage;
    logic               hazard;
    logic               load_unused;

    // The oldest slot's load flag is never consulted; keep it for a uniform shift.
    assign load_unused = ^load_q;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
            assign match_a[gi] = id_valid & id_rs1_used & valid_q[gi] & wr_q[gi]
                               & (rd_q[gi] == id_rs1_idx) & (id_rs1_idx != '0);
            assign match_b[gi] = id_valid & id_rs2_used & valid_q[gi] & wr_q[gi]
                               & (rd_q[gi] == id_rs2_idx) & (id_rs2_idx != '0);
            if (FWD_EN != 0) begin : g_fwd
                // A load is only a hazard while its data is not yet forwardable.
                if (gi < LOAD_LAT) begin : g_ld
                    assign haz_stage[gi] = load_q[gi] & (match_a[gi] | match_b[gi]);
                end else begin : g_nold
                    assign haz_stage[gi] = 1'b0;
                end
            end else begin : g_nofwd
                // WB is excluded: the register file writes through.
                if (gi < NSTAGES - 1) begin : g_chk
                    assign haz_stage[gi] = match_a[gi] | match_b[gi];
                end else begin : g_wb
                    assign haz_stage[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign hazard       = |haz_stage;
    assign stall        = hazard & ~flush;
    assign id_ex_bubble = stall | flush | ~id_valid;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

    // Priority select: scanning oldest to youngest lets the youngest match win.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (match_a[k]) fwd_a_sel = SEL_W'(k + 1);
            if (match_b[k]) fwd_b_sel = SEL_W'(k + 1);
        end
        if ((FWD_EN == 0) || stall) begin
            fwd_a_sel = '0;
            fwd_b_sel = '0;
        end
    end

    always_comb begin
        valid_d    = '0;
        wr_d       = '0;
        load_d     = '0;
        valid_d[0] = id_valid & ~stall & ~flush;
        wr_d[0]    = id_reg_wr;
        load_d[0]  = id_rd_mem;
        rd_d[0]    = id_rd_idx;
        for (int k = 1; k < NSTAGES; k++) begin
            valid_d[k] = valid_q[k-1] & ~(flush & (k < FLUSH_STAGES));
            wr_d[k]    = wr_q[k-1];
            load_d[k]  = load_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            wr_q        <= '0;
            load_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int k = 0; k < NSTAGES; k++) rd_q[k] <= '0;
        end else begin
            valid_q     <= valid_d;
            wr_q        <= wr_d;
            load_q      <= load_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            for (int k = 0; k < NSTAGES; k++) rd_q[k] <= rd_d[k];
        end
    end

endmodule
